// File: rtl/rab_arbiter.sv
// rab_arbiter: two-master (MCU, I2C) arbiter for the 8-bit register access bus.
//
// A master raises its write or read level. The arbiter grants one master and runs
// a fixed five-state transaction: IDLE -> ACCESS -> CAPTURE -> ACK -> RELEASE.
// From the cycle a request is sampled in IDLE (N), the register-file strobe is high
// at N+1, read data is captured at the end of N+2 and the one-cycle ack is high at N+3.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   mcu_rab_write/read/addr/wdata MCU request levels, address and write data
//   mcu_rab_ack, mcu_rab_rdata    MCU completion pulse and held read data
//   i2c_rab_*                     same set for the I2C master
//   rab_write/read/addr/wdata     register-file strobes, address and write data
//   rab_rdata                     register-file read data, valid one cycle after rab_read
//
// Configuration macro RAB_RR_EN:
//   defined   - round-robin on ties; the master not granted last wins
//   undefined - fixed priority; MCU always wins ties
// All outputs are registered.

module rab_arbiter #(
    parameter int unsigned RAB_ADDR_WIDTH = 9
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mcu_rab_write,
    input  logic                      mcu_rab_read,
    input  logic [RAB_ADDR_WIDTH-1:0] mcu_rab_addr,
    input  logic [7:0]                mcu_rab_wdata,
    output logic                      mcu_rab_ack,
    output logic [7:0]                mcu_rab_rdata,
    input  logic                      i2c_rab_write,
    input  logic                      i2c_rab_read,
    input  logic [RAB_ADDR_WIDTH-1:0] i2c_rab_addr,
    input  logic [7:0]                i2c_rab_wdata,
    output logic                      i2c_rab_ack,
    output logic [7:0]                i2c_rab_rdata,
    output logic                      rab_write,
    output logic                      rab_read,
    output logic [RAB_ADDR_WIDTH-1:0] rab_addr,
    output logic [7:0]                rab_wdata,
    input  logic [7:0]                rab_rdata
);

    typedef enum logic [2:0] {
        StIdle,
        StAccess,
        StCapture,
        StAck,
        StRelease
    } state_e;

    state_e state;
    logic   gnt_i2c;    // granted master of the current transaction
    logic   gnt_write;  // direction of the current transaction
    logic   mcu_req;
    logic   i2c_req;
    logic   pick_i2c;

`ifdef RAB_RR_EN
    logic   last_gnt_i2c;
`endif

    always_comb begin
        mcu_req = mcu_rab_write | mcu_rab_read;
        i2c_req = i2c_rab_write | i2c_rab_read;
`ifdef RAB_RR_EN
        pick_i2c = i2c_req && (!mcu_req || !last_gnt_i2c);
`else
        pick_i2c = i2c_req && !mcu_req;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= StIdle;
            gnt_i2c       <= 1'b0;
            gnt_write     <= 1'b0;
            mcu_rab_ack   <= 1'b0;
            i2c_rab_ack   <= 1'b0;
            mcu_rab_rdata <= 8'h00;
            i2c_rab_rdata <= 8'h00;
            rab_write     <= 1'b0;
            rab_read      <= 1'b0;
            rab_addr      <= '0;
            rab_wdata     <= 8'h00;
`ifdef RAB_RR_EN
            // Last grant reads as I2C so that MCU wins the first tie.
            last_gnt_i2c  <= 1'b1;
`endif
        end else begin
            // Strobes and acks are single-cycle pulses; default them low.
            mcu_rab_ack <= 1'b0;
            i2c_rab_ack <= 1'b0;
            rab_write   <= 1'b0;
            rab_read    <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (mcu_req || i2c_req) begin
                        gnt_i2c <= pick_i2c;
                        // Write wins when a master raises both levels.
                        if (pick_i2c) begin
                            gnt_write <= i2c_rab_write;
                            rab_write <= i2c_rab_write;
                            rab_read  <= !i2c_rab_write;
                            rab_addr  <= i2c_rab_addr;
                            rab_wdata <= i2c_rab_wdata;
                        end else begin
                            gnt_write <= mcu_rab_write;
                            rab_write <= mcu_rab_write;
                            rab_read  <= !mcu_rab_write;
                            rab_addr  <= mcu_rab_addr;
                            rab_wdata <= mcu_rab_wdata;
                        end
`ifdef RAB_RR_EN
                        last_gnt_i2c <= pick_i2c;
`endif
                        state <= StAccess;
                    end
                end
                StAccess: begin
                    state <= StCapture;
                end
                StCapture: begin
                    // rab_rdata is valid in this cycle, one after the rab_read strobe.
                    if (!gnt_write) begin
                        if (gnt_i2c) begin
                            i2c_rab_rdata <= rab_rdata;
                        end else begin
                            mcu_rab_rdata <= rab_rdata;
                        end
                    end
                    mcu_rab_ack <= !gnt_i2c;
                    i2c_rab_ack <= gnt_i2c;
                    state       <= StAck;
                end
                StAck: begin
                    state <= StRelease;
                end
                StRelease: begin
                    // Gap cycle that lets the served master drop its level.
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rab_arbiter.sv
// Scoreboard bench for rab_arbiter. Stimulus pushes hand-computed strobe and ack
// expectations (with their cycle numbers); negedge monitors pop and compare.

module tb_rab_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       mcu_rab_write, mcu_rab_read;
    logic [8:0] mcu_rab_addr;
    logic [7:0] mcu_rab_wdata;
    logic       mcu_rab_ack;
    logic [7:0] mcu_rab_rdata;
    logic       i2c_rab_write, i2c_rab_read;
    logic [8:0] i2c_rab_addr;
    logic [7:0] i2c_rab_wdata;
    logic       i2c_rab_ack;
    logic [7:0] i2c_rab_rdata;
    logic       rab_write, rab_read;
    logic [8:0] rab_addr;
    logic [7:0] rab_wdata;
    logic [7:0] rab_rdata;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        bit         wr;
        logic [8:0] addr;
        logic [7:0] wdata;
        int         cyc;
    } strobe_t;

    typedef struct {
        bit         i2c;
        logic [7:0] rdata;
        int         cyc;
    } ack_t;

    strobe_t sq[$];
    ack_t    aq[$];

    // Register-file model.
    logic [7:0] mem [512];
    logic       mem_clr;

    rab_arbiter #(.RAB_ADDR_WIDTH(9)) dut (
        .clk           (clk),
        .rst           (rst),
        .mcu_rab_write (mcu_rab_write),
        .mcu_rab_read  (mcu_rab_read),
        .mcu_rab_addr  (mcu_rab_addr),
        .mcu_rab_wdata (mcu_rab_wdata),
        .mcu_rab_ack   (mcu_rab_ack),
        .mcu_rab_rdata (mcu_rab_rdata),
        .i2c_rab_write (i2c_rab_write),
        .i2c_rab_read  (i2c_rab_read),
        .i2c_rab_addr  (i2c_rab_addr),
        .i2c_rab_wdata (i2c_rab_wdata),
        .i2c_rab_ack   (i2c_rab_ack),
        .i2c_rab_rdata (i2c_rab_rdata),
        .rab_write     (rab_write),
        .rab_read      (rab_read),
        .rab_addr      (rab_addr),
        .rab_wdata     (rab_wdata),
        .rab_rdata     (rab_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_clr) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
            mem[9'h1FF] <= 8'h3C;
            rab_rdata   <= 8'h00;
        end else begin
            if (rab_read) rab_rdata <= mem[rab_addr];
            if (rab_write) mem[rab_addr] <= rab_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_s(input bit wr, input logic [8:0] a, input logic [7:0] d, input int c);
        strobe_t e;
        e.wr = wr; e.addr = a; e.wdata = d; e.cyc = c;
        sq.push_back(e);
    endtask

    task automatic push_a(input bit i2c, input logic [7:0] r, input int c);
        ack_t e;
        e.i2c = i2c; e.rdata = r; e.cyc = c;
        aq.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Strobe monitor.
    always @(negedge clk) begin
        if (rab_write && rab_read) check("strobe_both", 32'(1), 32'(0));
        if (rab_write || rab_read) begin
            if (sq.size() == 0) begin
                check("strobe_unexpected", 32'(cyc), 32'(-1));
            end else begin
                strobe_t e;
                e = sq.pop_front();
                check("strobe_dir", 32'(rab_write), 32'(e.wr));
                check("strobe_addr", 32'(rab_addr), 32'(e.addr));
                if (e.wr) check("strobe_wdata", 32'(rab_wdata), 32'(e.wdata));
                check("strobe_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Ack monitor.
    always @(negedge clk) begin
        if (mcu_rab_ack && i2c_rab_ack) check("ack_both", 32'(1), 32'(0));
        if (mcu_rab_ack || i2c_rab_ack) begin
            if (aq.size() == 0) begin
                check("ack_unexpected", 32'(cyc), 32'(-1));
            end else begin
                ack_t e;
                e = aq.pop_front();
                check("ack_master", 32'(i2c_rab_ack), 32'(e.i2c));
                check("ack_rdata", 32'(i2c_rab_ack ? i2c_rab_rdata : mcu_rab_rdata),
                      32'(e.rdata));
                check("ack_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        int k;
        rst = 1'b1; mem_clr = 1'b1;
        mcu_rab_write = 0; mcu_rab_read = 0; mcu_rab_addr = '0; mcu_rab_wdata = '0;
        i2c_rab_write = 0; i2c_rab_read = 0; i2c_rab_addr = '0; i2c_rab_wdata = '0;
        tick(3);
        mem_clr = 1'b0;
        check("rst_mcu_ack", 32'(mcu_rab_ack), 32'(0));
        check("rst_i2c_ack", 32'(i2c_rab_ack), 32'(0));
        check("rst_strobes", 32'({rab_write, rab_read}), 32'(0));
        check("rst_addr", 32'(rab_addr), 32'(0));
        check("rst_wdata", 32'(rab_wdata), 32'(0));
        check("rst_rdata", 32'({mcu_rab_rdata, i2c_rab_rdata}), 32'(0));

        // MCU write right as reset drops; held through RELEASE then dropped.
        k = cyc;
        rst = 1'b0;
        mcu_rab_write = 1; mcu_rab_addr = 9'h010; mcu_rab_wdata = 8'hA5;
        push_s(1, 9'h010, 8'hA5, k + 1);
        push_a(0, 8'h00, k + 3);
        tick(4);
        mcu_rab_write = 0;
        tick(6);
        check("mcu_rdata_after_write", 32'(mcu_rab_rdata), 32'(8'h00));

        // I2C read of the top address.
        k = cyc;
        i2c_rab_read = 1; i2c_rab_addr = 9'h1FF;
        push_s(0, 9'h1FF, 8'h00, k + 1);
        push_a(1, 8'h3C, k + 3);
        tick(4);
        i2c_rab_read = 0;
        tick(4);
        check("i2c_rdata_held", 32'(i2c_rab_rdata), 32'(8'h3C));

        // MCU read+write together: served as a write only.
        k = cyc;
        mcu_rab_write = 1; mcu_rab_read = 1; mcu_rab_addr = 9'h020; mcu_rab_wdata = 8'h5A;
        push_s(1, 9'h020, 8'h5A, k + 1);
        push_a(0, 8'h00, k + 3);
        tick(4);
        mcu_rab_write = 0; mcu_rab_read = 0;
        tick(2);

        // MCU reads back what it wrote.
        k = cyc;
        mcu_rab_read = 1; mcu_rab_addr = 9'h020;
        push_s(0, 9'h020, 8'h00, k + 1);
        push_a(0, 8'h5A, k + 3);
        tick(4);
        mcu_rab_read = 0;
        tick(2);

        // I2C pulses a request mid-transaction and drops it: ignored, never served.
        k = cyc;
        mcu_rab_write = 1; mcu_rab_addr = 9'h040; mcu_rab_wdata = 8'h22;
        push_s(1, 9'h040, 8'h22, k + 1);
        push_a(0, 8'h5A, k + 3);
        tick(2);
        i2c_rab_read = 1; i2c_rab_addr = 9'h100;
        tick(1);
        i2c_rab_read = 0;
        tick(1);
        mcu_rab_write = 0;
        tick(4);

        // Request dropped after grant still completes.
        k = cyc;
        mcu_rab_read = 1; mcu_rab_addr = 9'h1FF;
        push_s(0, 9'h1FF, 8'h00, k + 1);
        push_a(0, 8'h3C, k + 3);
        tick(1);
        mcu_rab_read = 0;
        tick(5);

        // Reset in CAPTURE aborts: no ack, rdata cleared.
        k = cyc;
        mcu_rab_read = 1; mcu_rab_addr = 9'h020;
        push_s(0, 9'h020, 8'h00, k + 1);
        tick(2);
        rst = 1'b1;
        tick(1);
        check("abort_acks", 32'({mcu_rab_ack, i2c_rab_ack}), 32'(0));
        check("abort_strobes", 32'({rab_write, rab_read}), 32'(0));
        check("abort_rdata", 32'({mcu_rab_rdata, i2c_rab_rdata}), 32'(0));
        rst = 1'b0; mcu_rab_read = 0;
        tick(4);
        check("abort_mcu_rdata", 32'(mcu_rab_rdata), 32'(8'h00));

        // Tie after reset, both held for three grants.
        k = cyc;
        mcu_rab_write = 1; mcu_rab_addr = 9'h030; mcu_rab_wdata = 8'h11;
        i2c_rab_read = 1; i2c_rab_addr = 9'h1FF;
        push_s(1, 9'h030, 8'h11, k + 1);
        push_a(0, 8'h00, k + 3);
`ifdef RAB_RR_EN
        push_s(0, 9'h1FF, 8'h00, k + 6);
        push_a(1, 8'h3C, k + 8);
`else
        push_s(1, 9'h030, 8'h11, k + 6);
        push_a(0, 8'h00, k + 8);
`endif
        push_s(1, 9'h030, 8'h11, k + 11);
        push_a(0, 8'h00, k + 13);
        tick(14);
        mcu_rab_write = 0; i2c_rab_read = 0;
        tick(6);

        check("strobes_outstanding", 32'(sq.size()), 32'(0));
        check("acks_outstanding", 32'(aq.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rab_arbiter.md
RAB_ARBITER -- requirements
Module: rab_arbiter

Interface
REQ-001 Parameter: RAB_ADDR_WIDTH, 9, register-bus address width (512-byte window 16'hfe00~16'hffff).
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 mcu_rab_write / mcu_rab_read  input  1 each  MCU request levels.
REQ-005 mcu_rab_addr  input  RAB_ADDR_WIDTH; mcu_rab_wdata  input  8.
REQ-006 mcu_rab_ack  output  1  one-cycle completion pulse to MCU.
REQ-007 mcu_rab_rdata  output  8  MCU read data, valid while mcu_rab_ack=1.
REQ-008 i2c_rab_write / i2c_rab_read  input  1 each; i2c_rab_addr  input  RAB_ADDR_WIDTH; i2c_rab_wdata  input  8.
REQ-009 i2c_rab_ack  output  1; i2c_rab_rdata  output  8  (same meaning as MCU pair).
REQ-010 rab_write / rab_read  output  1 each  register-file strobes.
REQ-011 rab_addr  output  RAB_ADDR_WIDTH; rab_wdata  output  8; rab_rdata  input  8 (register-file read data, valid 1 cycle after rab_read).

Function
REQ-012 States SHALL be IDLE, ACCESS, CAPTURE, ACK, RELEASE; one-hot or binary encoding at implementer's choice.
REQ-013 IDLE: if any request is present, grant one master, latch its addr, wdata, direction; next state ACCESS; else stay.
REQ-014 Request = (write | read) of a master; write and read both high SHALL be served as write only.
REQ-015 ACCESS: exactly one cycle of rab_write or rab_read with latched addr/wdata; -> CAPTURE.
REQ-016 CAPTURE: on a read, sample rab_rdata into the granted master's rdata register at end of cycle; -> ACK.
REQ-017 ACK: granted master's ack = 1 for exactly one cycle; the other ack stays 0; -> RELEASE.
REQ-018 RELEASE: one idle cycle, no grant, so the requester can drop its level; -> IDLE.
REQ-019 Latency: request sampled in IDLE at cycle N -> rab_* strobe N+1 -> ack N+3; next grant earliest N+5.
REQ-020 All outputs SHALL be registered; rab_write/rab_read never high outside ACCESS.
REQ-021 mcu_rab_rdata / i2c_rab_rdata SHALL hold their last captured value until the next read by that master; writes do not modify them.
REQ-022 Request dropped before grant: not served, no ack. Request dropped after grant: access still completes, ack still issued.
REQ-023 Inputs other than the granted master's are ignored from IDLE exit until re-entry to IDLE.
REQ-024 Simultaneous MCU and I2C requests in IDLE: resolved per REQ-029/REQ-030.

Reset
REQ-025 rst=1 at a clock edge SHALL force state IDLE, all acks 0, rab_write/rab_read 0, rab_addr 0, rab_wdata 0, both rdata registers 8'h00, last-grant flag = I2C (MCU wins first tie).
REQ-026 Reset mid-transaction aborts it: no ack and no further strobe for the aborted access.
REQ-027 First grant possible on the first edge after rst deasserts.

Configuration
REQ-028 Macro: RAB_RR_EN.
REQ-029 RAB_RR_EN defined: round-robin on ties; the master not granted last wins; last-grant flag updated at every grant.
REQ-030 RAB_RR_EN undefined: fixed priority, MCU always wins ties; last-grant flag absent.

Verification
REQ-031 MCU write addr 9'h010 data 8'hA5, no I2C -> rab_write=1 one cycle at N+1 with addr 9'h010/data 8'hA5; mcu_rab_ack=1 at N+3; i2c_rab_ack stays 0.
REQ-032 I2C read addr 9'h1FF, reg file returns 8'h3C -> rab_read at N+1; i2c_rab_ack at N+3 with i2c_rab_rdata=8'h3C, held after ack.
REQ-033 Both request at same edge, held, after reset -> MCU served first; with RAB_RR_EN: I2C next, then MCU; without: MCU re-wins while held.
REQ-034 MCU read and write both high, addr 9'h020 -> only rab_write issued; mcu_rab_rdata unchanged.
REQ-035 rst asserted in CAPTURE -> no ack, state IDLE next cycle, rdata registers 8'h00.
REQ-036 Request held through RELEASE then dropped -> exactly one access, one ack per request.
